// File: rtl/arb_merge2_if.sv
// ============================================================================
// Module   : arb_merge2_if
// Brief    : Valid/ready bundle for the two arbiter inputs and the output reg.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface arb_merge2_if #(
    parameter int W = 9
);
    logic         in0_valid;
    logic [W-1:0] in0_data;
    logic         in0_ready;
    logic         in1_valid;
    logic [W-1:0] in1_data;
    logic         in1_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_sel;
    logic         out_ready;

    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  in0_ready, in1_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output in0_ready, in1_ready, out_valid, out_data, out_sel
    );
endinterface

`default_nettype wire

// File: rtl/arb_merge2.sv
// ============================================================================
// Module   : arb_merge2
// Brief    : Two-input round-robin merge into a single output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_merge2 #(
    parameter int W     = 9,
    parameter int CNT_W = 8
) (
    input  wire logic             CLK,
    input  wire logic             _RESET,
    arb_merge2_if.slave           bus,
    input  wire logic             clr_cnt,
    output logic      [CNT_W-1:0] cnt0,
    output logic      [CNT_W-1:0] cnt1,
    output logic                  prio
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic   [W-1:0]     data_q, data_d;
    logic               sel_q, sel_d;
    logic               prio_q, prio_d;
    logic   [CNT_W-1:0] cnt0_q, cnt0_d;
    logic   [CNT_W-1:0] cnt1_q, cnt1_d;

    logic can_load;
    logic rdy0;
    logic rdy1;
    logic grant0;
    logic grant1;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        // Each ready looks only at the other input's valid, so no input can
        // form a combinational loop through its own handshake.
        can_load = (state_q == ST_EMPTY) | bus.out_ready;
        rdy0     = can_load & (~prio_q | ~bus.in1_valid);
        rdy1     = can_load & ( prio_q | ~bus.in0_valid);
        grant0   = bus.in0_valid & rdy0;
        grant1   = bus.in1_valid & rdy1;

        case (state_q)
            ST_EMPTY: if (grant0 | grant1) state_d = ST_FULL;
            ST_FULL:  if (bus.out_ready & ~(grant0 | grant1)) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (grant0) begin
            data_d = bus.in0_data;
            sel_d  = 1'b0;
            prio_d = 1'b1;
        end else if (grant1) begin
            data_d = bus.in1_data;
            sel_d  = 1'b1;
            prio_d = 1'b0;
        end

        // Clear has priority over a same-cycle grant; counters saturate.
        if (clr_cnt) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (grant0 && cnt0_q != c_cnt_max) cnt0_d = cnt0_q + c_cnt_one;
            if (grant1 && cnt1_q != c_cnt_max) cnt1_d = cnt1_q + c_cnt_one;
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus.in0_ready = rdy0;
    assign bus.in1_ready = rdy1;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign cnt0          = cnt0_q;
    assign cnt1          = cnt1_q;
    assign prio          = prio_q;

endmodule

`default_nettype wire

// File: doc/arb_merge2.md
ARB_MERGE2 -- requirements
Module: arb_merge2

Interface
REQ-001 Parameter W, default 9, meaning packet width; bits [8:5] carry the 4-bit destination address.
REQ-002 Parameter CNT_W, default 8, meaning width of each per-input grant counter.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 _RESET  input  1  reset, asynchronous, active-low; asserting it clears all state immediately, independent of CLK.
REQ-005 in0_valid  input  1  input 0 presents a packet.
REQ-006 in0_data  input  W  input 0 packet.
REQ-007 in0_ready  output  1  arbiter accepts input 0 this cycle.
REQ-008 in1_valid  input  1  input 1 presents a packet.
REQ-009 in1_data  input  W  input 1 packet.
REQ-010 in1_ready  output  1  arbiter accepts input 1 this cycle.
REQ-011 out_valid  output  1  output register holds a packet.
REQ-012 out_data  output  W  held packet.
REQ-013 out_sel  output  1  source of the held packet: 0 = in0, 1 = in1.
REQ-014 out_ready  input  1  downstream (decoder stage) consumes the packet.
REQ-015 clr_cnt  input  1  synchronous clear of both grant counters.
REQ-016 cnt0, cnt1  output  CNT_W each  grants issued to in0 and in1.
REQ-017 prio  output  1  current round-robin pointer, i.e. the preferred input.

Function
REQ-018 Transfers occur on any port only when valid and ready are both 1 at posedge CLK.
REQ-019 State EMPTY (out_valid=0) and state FULL (out_valid=1); no other states.
REQ-020 can_load = EMPTY, or FULL with out_ready=1 in the same cycle.
REQ-021 in0_ready = can_load & (prio==0 | ~in1_valid).
REQ-022 in1_ready = can_load & (prio==1 | ~in0_valid).
REQ-023 ready shall never depend combinationally on the same input's own valid.
REQ-024 At most one input transfer per cycle.
REQ-025 Both valid and can_load: grant goes to input prio.
REQ-026 One valid and can_load: that input is granted regardless of prio.
REQ-027 On a grant to input i: out_data <= in_i_data; out_sel <= i; out_valid <= 1; prio <= ~i; cnt_i increments.
REQ-028 Latency is exactly 1 cycle from input transfer to out_valid=1.
REQ-029 Throughput is 1 packet/cycle while out_ready=1.
REQ-030 Transitions: EMPTY->FULL on grant. FULL->EMPTY on out_ready with no grant. FULL->FULL on out_ready with grant (back-to-back). FULL holds with out_ready=0.
REQ-031 While FULL and out_ready=0: out_data, out_sel and prio shall hold, and both in*_ready shall be 0.
REQ-032 prio changes only on a grant.
REQ-033 Fairness: with both inputs continuously valid, grants strictly alternate.
REQ-034 Counters saturate at 2^CNT_W-1 and do not wrap.
REQ-035 clr_cnt=1 sets both counters to 0; clear wins over a simultaneous increment.
REQ-036 out_data is passed unmodified; the arbiter never inspects the address bits.

Reset
REQ-037 While _RESET=0: out_valid=0, out_data=0, out_sel=0, prio=0, cnt0=cnt1=0.
REQ-038 A packet held at reset assertion is discarded; no partial output.
REQ-039 After release: in0_ready=1, in1_ready=~in0_valid; first cycle behaves as EMPTY.

Verification
REQ-040 Reset, then in0 only, in0_data=9'h1A5, out_ready=1 -> next cycle out_valid=1, out_data=9'h1A5, out_sel=0, prio=1, cnt0=1.
REQ-041 Both valid for 4 cycles, out_ready=1 -> out_sel sequence 0,1,0,1; cnt0=2, cnt1=2.
REQ-042 FULL with out_ready=0 for 3 cycles and both inputs valid -> in0_ready=in1_ready=0; out_data/out_sel/prio stable; no counter change.
REQ-043 CNT_W=2, 5 grants to in1 -> cnt1 stops at 3; clr_cnt pulsed during a grant -> cnt1=0.
REQ-044 _RESET asserted mid-cycle while FULL -> out_valid=0 immediately, before the next CLK edge; prio=0 after release.
REQ-045 Random valid/out_ready stress, 10k cycles -> no packet lost or duplicated, order preserved per input, no input waits more than 1 grant while valid.
